instr_encoder: RTL and testbench
================================

# instr_encoder

Streaming RV32I instruction encoder: the inverse of the immediate-extraction path in the decode stage. Takes decoded fields (format, registers, funct, 32-bit signed immediate) over a valid/ready handshake. Packs them into 32-bit R/I-load/S/B-format instruction words and emits each word with an auto-incrementing instruction-memory byte address through a 2-entry output buffer. Used by the program loader and by self-test benches to build instruction memory images.

## Interface
- `BASE_ADDR`, 32'h0000_0000, address assigned to the first word after reset or `clear`
- `ADDR_W`, 32, width of `out_addr` and the internal address counter
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `clear`  in  1  synchronous flush: empties buffer, reloads address to `BASE_ADDR`, clears `err`
- `in_valid`  in  1  field set valid
- `in_ready`  out  1  encoder can accept a field set
- `fmt`  in  2  0=R (opcode 0110011), 1=I-load (0000011), 2=S (0100011), 3=B (1100011)
- `rd`, `rs1`, `rs2`  in  5 each  register indices
- `funct3`  in  3  funct3 field
- `funct7`  in  7  funct7 field (R only)
- `imm`  in  32  signed immediate, byte offset for B
- `out_valid`  out  1  buffer head valid
- `out_ready`  in  1  consumer accepts head
- `out_instr`  out  32  encoded instruction word
- `out_addr`  out  ADDR_W  byte address of `out_instr`
- `err`  out  1  sticky: at least one field set was rejected

## Operation
Field placement is bit-exact RV32I:
- R: {funct7, rs2, rs1, funct3, rd, op}
- I: {imm[11:0], rs1, funct3, rd, op}
- S: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}
- B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}
- Unused fields are ignored: `rs2`/`funct7` for I; `rd`/`funct7` for S/B; `imm` for R.

Handshake and buffering:
- Accept occurs when `in_valid && in_ready`.
- `in_ready` = buffer count < 2; registered from count, with no combinational path from `out_ready`.
- A good accept pushes {word, addr_cnt} and advances addr_cnt by 4, wrapping modulo 2^ADDR_W.
- Pop occurs when `out_valid && out_ready`. The buffer is FIFO-ordered.
- Simultaneous push and pop with count=1: count stays 1; order is preserved.
- `clear` has priority over push and pop in the same cycle, and the accepted field set is discarded.

Rejected field sets (range check, see Configuration):
- The field set is still accepted (handshake completes) but nothing is pushed.
- addr_cnt is unchanged and `err` is set.
- `err` holds until `rst` or `clear`.

Reset (asynchronous, including mid-transfer): buffer empty, `out_valid`=0, `in_ready`=1 on the first cycle after release, `out_instr`=0, `out_addr`=0, addr_cnt=`BASE_ADDR`, `err`=0.

## Timing
- Latency: a word accepted at edge N is visible with `out_valid`=1 after edge N, so it is poppable at edge N+1.
- Throughput: 1 word/cycle while `out_ready`=1.
- Buffer full: `in_ready`=0 from the edge the second entry lands until the edge after a pop.
- `out_instr`/`out_addr` are stable while `out_valid`=1 and `out_ready`=0.
- `err` rises the edge after the rejected accept.

## Configuration
`INSTR_ENCODER_RANGE_CHECK_EN` is compiled in:
- I/S reject `imm` outside -2048..2047.
- B rejects `imm` outside -4096..4094 or odd.
- R is never rejected.

`INSTR_ENCODER_RANGE_CHECK_EN` is compiled out:
- No rejection; immediates are truncated to the encoded bits (B drops imm[0]).
- `err` is tied to 0.

## Test plan
- R: fmt=0, funct7=0, rs2=2, rs1=1, funct3=0, rd=3 after reset -> `out_instr`=32'h002081B3, `out_addr`=0.
- I then S back-to-back, `out_ready`=1:
  - lw: rs1=2, funct3=2, rd=5, imm=-4 -> 32'hFFC12283 @0x0.
  - sw: rs2=6, rs1=1, funct3=2, imm=8 -> 32'h0060A423 @0x4.
  - One word per cycle.
- B: rs1=1, rs2=2, funct3=0, imm=-8 -> 32'hFE208CE3.
- Backpressure: `out_ready`=0, offer 3 sets -> `in_ready` drops after 2. Raise `out_ready` -> 3 words in order at 0x0, 0x4, 0x8.
- Range, macro on: I imm=2048 -> no output, `err`=1, next good word at unchanged address. Macro off: same stimulus -> 32'h80012283, `err`=0.
- `rst` asserted with 2 words buffered -> `out_valid`=0 immediately. First word after release at `BASE_ADDR`.

Source files
------------

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - streaming RV32I R/I-load/S/B instruction encoder with 2-entry output buffer
//
// Optional feature macro: INSTR_ENCODER_RANGE_CHECK_EN (immediate range check, sticky err)
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   clear               synchronous flush: empty buffer, reload address, clear err
//   in_valid/in_ready   field-set handshake (in_ready registered from buffer count)
//   fmt                 0=R, 1=I-load, 2=S, 3=B
//   rd, rs1, rs2        register indices
//   funct3, funct7      function fields
//   imm                 32-bit signed immediate (byte offset for B)
//   out_valid/out_ready output handshake on buffer head
//   out_instr, out_addr encoded word and its instruction-memory byte address
//   err                 sticky: a field set was rejected
module instr_encoder #(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err
);

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;

  // Slot 0 is always the buffer head; slot 1 is only meaningful when count is 2.
  logic [1:0]        count_q, count_d;
  logic [31:0]       instr0_q, instr0_d, instr1_q, instr1_d;
  logic [ADDR_W-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              err_q, err_d;

  logic [31:0] word;
  logic        reject;
  logic        accept, push, pop;

  always_comb begin
    word = '0;
    case (fmt)
      2'd0: word = {funct7, rs2, rs1, funct3, rd, OP_R};
      2'd1: word = {imm[11:0], rs1, funct3, rd, OP_I};
      2'd2: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_S};
      2'd3: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_B};
      default: word = '0;
    endcase
  end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  logic signed [31:0] imm_s;
  assign imm_s = imm;

  always_comb begin
    reject = 1'b0;
    case (fmt)
      2'd1, 2'd2: reject = (imm_s < -2048) || (imm_s > 2047);
      2'd3:       reject = (imm_s < -4096) || (imm_s > 4094) || imm[0];
      default:    reject = 1'b0;
    endcase
  end
`else
  // Without the check the immediate is simply truncated to the encoded bits.
  logic unused_imm;
  assign unused_imm = ^{imm[31:13], imm[0]};
  assign reject     = 1'b0;
`endif

  assign out_valid = (count_q != 2'd0);
  assign accept    = in_valid && in_ready_q;
  assign push      = accept && !reject && !clear;
  assign pop       = out_valid && out_ready && !clear;

  always_comb begin
    count_d    = count_q;
    instr0_d   = instr0_q;
    instr1_d   = instr1_q;
    addr0_d    = addr0_q;
    addr1_d    = addr1_q;
    addr_cnt_d = addr_cnt_q;
    err_d      = err_q;

    if (clear) begin
      count_d    = 2'd0;
      addr_cnt_d = BASE_ADDR;
      err_d      = 1'b0;
    end else begin
      if (accept && reject) err_d = 1'b1;
      if (push) addr_cnt_d = addr_cnt_q + ADDR_W'(4);

      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            instr0_d = word;
            addr0_d  = addr_cnt_q;
          end else begin
            instr1_d = word;
            addr1_d  = addr_cnt_q;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          instr0_d = instr1_q;
          addr0_d  = addr1_q;
          count_d  = count_q - 2'd1;
        end
        // Push needs count<2 and pop needs count>0, so count is 1 here:
        // the new word simply replaces the departing head.
        2'b11: begin
          instr0_d = word;
          addr0_d  = addr_cnt_q;
        end
        default: ;
      endcase
    end

    in_ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= 2'd0;
      instr0_q   <= '0;
      instr1_q   <= '0;
      addr0_q    <= '0;
      addr1_q    <= '0;
      addr_cnt_q <= BASE_ADDR;
      in_ready_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      instr0_q   <= instr0_d;
      instr1_q   <= instr1_d;
      addr0_q    <= addr0_d;
      addr1_q    <= addr1_d;
      addr_cnt_q <= addr_cnt_d;
      in_ready_q <= in_ready_d;
      err_q      <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_instr = instr0_q;
  assign out_addr  = addr0_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder
module tb_instr_encoder;

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, in_ready, out_valid, out_ready, err;
  logic [1:0]  fmt;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm, out_instr, out_addr;

  int checks = 0;
  int errors = 0;

  instr_encoder dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  fmt;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    bit          rej;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] f, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] im);
    fmt = f; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  logic [31:0] exp_addr;
  logic        exp_err;

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    fmt = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;

    vecs[0]  = '{2'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0,           32'h002081B3, 1'b0};
    vecs[1]  = '{2'd1, 5'd5, 5'd2, 5'd0, 3'd2, 7'h00, -32'sd4,         32'hFFC12283, 1'b0};
    vecs[2]  = '{2'd2, 5'd0, 5'd1, 5'd6, 3'd2, 7'h00, 32'd8,           32'h0060A423, 1'b0};
    vecs[3]  = '{2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, -32'sd8,         32'hFE208CE3, 1'b0};
    vecs[4]  = '{2'd1, 5'd5, 5'd2, 5'd0, 3'd2, 7'h00, 32'd2047,        32'h7FF12283, 1'b0};
    vecs[5]  = '{2'd1, 5'd5, 5'd2, 5'd0, 3'd2, 7'h00, -32'sd2048,      32'h80012283, 1'b0};
    vecs[6]  = '{2'd1, 5'd5, 5'd2, 5'd0, 3'd2, 7'h00, 32'd2048,        32'h80012283, RC};
    vecs[7]  = '{2'd2, 5'd0, 5'd1, 5'd6, 3'd2, 7'h00, -32'sd2049,      32'h7E60AFA3, RC};
    vecs[8]  = '{2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd4094,        32'h7E208FE3, 1'b0};
    vecs[9]  = '{2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, -32'sd4096,      32'h80208063, 1'b0};
    vecs[10] = '{2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'd3,           32'h00208163, RC};
    vecs[11] = '{2'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h12345678,    32'h402081B3, 1'b0};

    // Reset state
    #7;
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    rst = 1'b0;
    tick();
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_out_instr", out_instr, 32'd0);
    chk("reset_out_addr", out_addr, 32'd0);
    chk("reset_err", {31'b0, err}, 32'd0);

    // Table: one field set at a time, drained immediately
    exp_addr  = 32'd0;
    exp_err   = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].fmt, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].f3, vecs[i].f7, vecs[i].imm);
      tick();
      in_valid = 1'b0;
      if (vecs[i].rej) begin
        exp_err = 1'b1;
        chk($sformatf("vec%0d_no_output", i), {31'b0, out_valid}, 32'd0);
      end else begin
        chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'd1);
        chk($sformatf("vec%0d_instr", i), out_instr, vecs[i].exp_instr);
        chk($sformatf("vec%0d_addr", i), out_addr, exp_addr);
        exp_addr = exp_addr + 32'd4;
      end
      chk($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, exp_err});
      tick();
      chk($sformatf("vec%0d_drained", i), {31'b0, out_valid}, 32'd0);
    end

    do_clear();
    chk("clear_err", {31'b0, err}, 32'd0);

    // Back-to-back lw then sw, one word per cycle
    drive(2'd1, 5'd5, 5'd2, 5'd0, 3'd2, 7'h00, -32'sd4);
    tick();
    chk("b2b_lw_instr", out_instr, 32'hFFC12283);
    chk("b2b_lw_addr", out_addr, 32'h0);
    chk("b2b_ready", {31'b0, in_ready}, 32'd1);
    drive(2'd2, 5'd0, 5'd1, 5'd6, 3'd2, 7'h00, 32'd8);
    tick();
    in_valid = 1'b0;
    chk("b2b_sw_instr", out_instr, 32'h0060A423);
    chk("b2b_sw_addr", out_addr, 32'h4);
    chk("b2b_sw_valid", {31'b0, out_valid}, 32'd1);
    tick();
    chk("b2b_empty", {31'b0, out_valid}, 32'd0);

    // Backpressure: three sets offered with out_ready low
    do_clear();
    out_ready = 1'b0;
    drive(2'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0);
    tick();
    drive(2'd0, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0);
    tick();
    chk("bp_full_ready", {31'b0, in_ready}, 32'd0);
    drive(2'd0, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0);
    tick();
    chk("bp_still_full", {31'b0, in_ready}, 32'd0);
    chk("bp_head_stable_instr", out_instr, 32'h000000B3);
    chk("bp_head_stable_addr", out_addr, 32'h0);
    out_ready = 1'b1;
    tick();
    chk("bp_second_instr", out_instr, 32'h00000133);
    chk("bp_second_addr", out_addr, 32'h4);
    chk("bp_ready_back", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_third_instr", out_instr, 32'h000001B3);
    chk("bp_third_addr", out_addr, 32'h8);
    tick();
    chk("bp_drained", {31'b0, out_valid}, 32'd0);

    // Clear beats a concurrent push and pop
    out_ready = 1'b0;
    drive(2'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0);
    tick();
    out_ready = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    chk("clr_empty", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;
    drive(2'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0);
    tick();
    in_valid = 1'b0;
    chk("clr_addr_base", out_addr, 32'h0);
    chk("clr_instr", out_instr, 32'h002081B3);

    // Asynchronous reset with two words buffered
    drive(2'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0);
    tick();
    in_valid = 1'b0;
    chk("rst_pre_full", {31'b0, in_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", {31'b0, out_valid}, 32'd0);
    #10 rst = 1'b0;
    tick();
    chk("rst_release_ready", {31'b0, in_ready}, 32'd1);
    drive(2'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0);
    tick();
    in_valid = 1'b0;
    chk("rst_first_addr", out_addr, 32'h0);
    chk("rst_first_instr", out_instr, 32'h002081B3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
